// File: rtl/user_input_conditioner_if.sv
// Signal bundle between the raw user-input source and the conditioner.
// master drives the raw levels and clear pulse; slave (the conditioner) drives the conditioned outputs.
interface user_input_conditioner_if;
  logic joystick_up;
  logic joystick_down;
  logic arcade_button_pressed;
  logic clear_inputs;
  logic paddle_step_up;
  logic paddle_step_down;
  logic button_level;
  logic button_event;
  logic arcade_led;

  modport master (
    output joystick_up, joystick_down, arcade_button_pressed, clear_inputs,
    input  paddle_step_up, paddle_step_down, button_level, button_event, arcade_led
  );

  modport slave (
    input  joystick_up, joystick_down, arcade_button_pressed, clear_inputs,
    output paddle_step_up, paddle_step_down, button_level, button_event, arcade_led
  );
endinterface

// File: rtl/user_input_conditioner.sv
// Synchronize, debounce and condition joystick/button inputs into paddle step pulses and a sticky button event.
// Optional macro ARCADE_LED_BLINK_EN: blink arcade_led while button_event is set (otherwise LED follows button_event).
module user_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_CYCLES   = 250_000,
  parameter int BLINK_CYCLES    = 12_500_000
) (
  input logic                     clock,
  input logic                     reset,
  user_input_conditioner_if.slave bus
);

  localparam int NIN = 3;  // bit 0 = up, bit 1 = down, bit 2 = button
  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int RW  = $clog2(REPEAT_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_param_chk
    $error("user_input_conditioner: parameter out of range");
  end

  logic [NIN-1:0]         raw;
  logic [NIN-1:0]         s1_q, s2_q;
  logic [NIN-1:0]         stable_q, stable_d;
  logic [NIN-1:0]         rise;
  logic [NIN-1:0][DW-1:0] cnt_q, cnt_d;

  assign raw = {bus.arcade_button_pressed, bus.joystick_down, bus.joystick_up};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Any sample agreeing with the stable level restarts the count, so glitches never accumulate.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = '0;
    for (int i = 0; i < NIN; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        rise[i]     = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_e;

  state_e          state_q;
  logic [RW-1:0]   rep_q;
  logic            step_up_q, step_dn_q;
  logic            up_only, dn_only;

  assign up_only = stable_q[0] & ~stable_q[1];
  assign dn_only = stable_q[1] & ~stable_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rep_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (up_only) begin
            state_q   <= S_UP;
            step_up_q <= 1'b1;
            rep_q     <= '0;
          end else if (dn_only) begin
            state_q   <= S_DOWN;
            step_dn_q <= 1'b1;
            rep_q     <= '0;
          end
        end
        S_UP: begin
          if (up_only) begin
            if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
              step_up_q <= 1'b1;
              rep_q     <= '0;
            end else begin
              rep_q <= rep_q + RW'(1);
            end
          end else if (dn_only) begin
            state_q   <= S_DOWN;
            step_dn_q <= 1'b1;
            rep_q     <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DOWN: begin
          if (dn_only) begin
            if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
              step_dn_q <= 1'b1;
              rep_q     <= '0;
            end else begin
              rep_q <= rep_q + RW'(1);
            end
          end else if (up_only) begin
            state_q   <= S_UP;
            step_up_q <= 1'b1;
            rep_q     <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A press landing on the same edge as a clear wins, so no press is ever dropped.
  logic ev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ev_q <= 1'b0;
    else       ev_q <= rise[2] | (ev_q & ~bus.clear_inputs);
  end

`ifdef ARCADE_LED_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          led_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      led_q       <= 1'b0;
    end else if (!ev_q) begin
      blink_cnt_q <= '0;
      led_q       <= 1'b0;
    end else begin
      if (blink_cnt_q == '0) led_q <= ~led_q;
      blink_cnt_q <= (blink_cnt_q == BW'(BLINK_CYCLES - 1)) ? '0 : blink_cnt_q + BW'(1);
    end
  end

  assign bus.arcade_led = led_q & ev_q;
`else
  assign bus.arcade_led = ev_q;
`endif

  assign bus.paddle_step_up   = step_up_q;
  assign bus.paddle_step_down = step_dn_q;
  assign bus.button_level     = stable_q[2];
  assign bus.button_event     = ev_q;

endmodule

// File: tb/tb_user_input_conditioner.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural model, a monitor pops and compares.
module tb_user_input_conditioner;
  localparam int DEB = 4;
  localparam int REP = 8;
  localparam int BLK = 3;

  typedef struct packed {
    logic su;
    logic sd;
    logic lvl;
    logic ev;
    logic led;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  user_input_conditioner_if bus();

  user_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP),
    .BLINK_CYCLES   (BLK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: a raw level reaches the debouncer two edges late; the debounced level flips once
  // the opposite value has been seen on DEB consecutive edges. A direction held alone for a
  // run of r cycles earns a step on the following edge whenever (r-1) is a multiple of REP.
  logic [1:0] m_pipe [3];
  logic       m_stable [3];
  int         m_diff [3];
  int         m_dir;   // 0 none/both, 1 up only, 2 down only
  int         m_run;
  logic       m_blev;
  logic       m_ev;
  int         m_evj;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_pipe[i]   = 2'b00;
      m_stable[i] = 1'b0;
      m_diff[i]   = 0;
    end
    m_dir  = 0;
    m_run  = 0;
    m_blev = 1'b0;
    m_ev   = 1'b0;
    m_evj  = 0;
  endtask

  task automatic model_step(input logic u, input logic d, input logic b, input logic c);
    exp_t       e;
    logic [2:0] rawv;
    logic       prev_ev;
    logic       rise;
    int         nd;
    e    = '0;
    rawv = {b, d, u};
    if (reset) begin
      model_clear();
    end else begin
      e.su = (m_dir == 1) && (((m_run - 1) % REP) == 0);
      e.sd = (m_dir == 2) && (((m_run - 1) % REP) == 0);
      for (int i = 0; i < 3; i++) begin
        logic seen;
        seen      = m_pipe[i][1];
        m_pipe[i] = {m_pipe[i][0], rawv[i]};
        if (seen == m_stable[i]) m_diff[i] = 0;
        else begin
          m_diff[i]++;
          if (m_diff[i] == DEB) begin
            m_stable[i] = seen;
            m_diff[i]   = 0;
          end
        end
      end
      nd = (m_stable[0] && !m_stable[1]) ? 1 : (m_stable[1] && !m_stable[0]) ? 2 : 0;
      if (nd != 0 && nd == m_dir) m_run++;
      else m_run = 1;
      m_dir   = nd;
      rise    = m_stable[2] && !m_blev;
      m_blev  = m_stable[2];
      prev_ev = m_ev;
      m_ev    = rise || (m_ev && !c);
      if (m_ev && prev_ev) m_evj++;
      else m_evj = 0;
      e.lvl = m_stable[2];
      e.ev  = m_ev;
`ifdef ARCADE_LED_BLINK_EN
      e.led = m_ev && (m_evj >= 1) && ((((m_evj - 1) / BLK) % 2) == 0);
`else
      e.led = m_ev;
`endif
    end
    expq.push_back(e);
  endtask

  // Apply one set of inputs for the next clock edge; returns 1 time unit after that edge.
  task automatic tick(input logic u, input logic d, input logic b, input logic c);
    bus.joystick_up           = u;
    bus.joystick_down         = d;
    bus.arcade_button_pressed = b;
    bus.clear_inputs          = c;
    @(posedge clock);
    model_step(u, d, b, c);
    #1;
  endtask

  // Reset lands between edges: the entry already queued for this cycle must now read all-zero.
  task automatic do_reset(input int n);
    exp_t z;
    z     = '0;
    reset = 1'b1;
    model_clear();
    if (expq.size() > 0) expq[expq.size() - 1] = z;
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic chk(input string nm, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("paddle_step_up",   bus.paddle_step_up,   e.su);
        chk("paddle_step_down", bus.paddle_step_down, e.sd);
        chk("button_level",     bus.button_level,     e.lvl);
        chk("button_event",     bus.button_event,     e.ev);
        chk("arcade_led",       bus.arcade_led,       e.led);
      end
    end
  end

  initial begin
    logic ru, rd, rb, rc;
    bus.joystick_up           = 1'b0;
    bus.joystick_down         = 1'b0;
    bus.arcade_button_pressed = 1'b0;
    bus.clear_inputs          = 1'b0;
    model_clear();
    do_reset(3);
    repeat (20) tick(1'b0, 1'b0, 1'b0, 1'b0);
    // short up glitch
    repeat (3)  tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    // up held: entry step then repeats
    repeat (40) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 1'b0, 1'b0);
    // both held, then up released with down still held
    repeat (20) tick(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 1'b0, 1'b0);
    // button press, release, clear
    repeat (10) tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    // clear on the very edge the debounced press rises, then clear while still held
    repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    // reset mid-operation
    repeat (12) tick(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset(2);
    // randomized levels with occasional clears and resets
    ru = 1'b0; rd = 1'b0; rb = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0)  ru = ~ru;
      if ($urandom_range(0, 9) == 0)  rd = ~rd;
      if ($urandom_range(0, 11) == 0) rb = ~rb;
      rc = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 999) == 0) do_reset(2);
      else tick(ru, rd, rb, rc);
    end
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
